// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search used by the UART TX arbiter.
package uart_arb_pkg;

   localparam int BYTE_W  = 8;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01
   } arb_state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First set bit of req at or after ptr, wrapping modulo n.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input logic [2:0]         ptr,
                                     input int unsigned        n);
      pick_t       res;
      int unsigned pos;
      res = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         pos = (32'(ptr) + k) % n;
         if ((k < n) && !res.found && req[pos[2:0]]) begin
            res.found = 1'b1;
            res.idx   = pos[2:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational winner selection for the TX arbiter.
// UART_ARB_PRIO_EN makes requester 0 a fixed highest priority.
module uart_rr_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    winner,
   output logic               any_req
);

   logic [MAX_REQ-1:0] req_ext;
   logic [2:0]         ptr_ext;
   pick_t              pick;

   always_comb begin
      req_ext               = '0;
      req_ext[NUM_REQ-1:0]  = req;
      ptr_ext               = '0;
      ptr_ext[ID_W-1:0]     = rr_ptr;
`ifdef UART_ARB_PRIO_EN
      if (req_ext[0]) begin
         pick.found = 1'b1;
         pick.idx   = '0;
      end else begin
         pick = rr_pick(req_ext & 8'hFE, ptr_ext, NUM_REQ);
      end
`else
      pick = rr_pick(req_ext, ptr_ext, NUM_REQ);
`endif
      winner  = pick.idx[ID_W-1:0];
      any_req = pick.found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO push port between requesters.
// Optional fixed priority for requester 0 via UART_ARB_PRIO_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16,
   parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [BYTE_W-1:0]         fifo_wdata,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [7:0]        burst_cnt_q, burst_cnt_d;

   logic [ID_W-1:0]   pick_winner;
   logic              pick_any;
   logic              sel_valid;
   logic              sel_last;
   logic [BYTE_W-1:0] sel_data;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .winner  (pick_winner),
      .any_req (pick_any)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == grant_id_q) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      req_ready   = '0;
      fifo_wr_en  = 1'b0;
      fifo_wdata  = '0;
      busy        = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_id_d  = pick_winner;
               burst_cnt_d = '0;
               state_d     = XFER;
            end
         end
         XFER: begin
            busy = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (ID_W'(i) == grant_id_q) req_ready[i] = !fifo_full;
            end
            fifo_wr_en = sel_valid & !fifo_full;
            if (fifo_wr_en) begin
               fifo_wdata = sel_data;
               // Last byte and burst limit share one release path.
               if (sel_last || (burst_cnt_q == 8'(MAX_BURST - 1))) begin
                  burst_cnt_d = '0;
                  rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                                                   : grant_id_q + ID_W'(1);
                  state_d     = IDLE;
               end else begin
                  burst_cnt_d = burst_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign grant_id = grant_id_q;

endmodule
